// File: rtl/capture_sequencer.sv
// Frame-capture scheduler: programs shutter time over the register bus, triggers the
// timing FSM, counts active lines per frame and handles burst/continuous/abort/timeout.
module capture_sequencer #(
    parameter int LINES_PER_FRAME = 3325,
    parameter int SETTLE_CYCLES   = 4,
    parameter int LINE_TIMEOUT    = 8192,
    parameter int DRAIN_CYCLES    = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_mode_i,
    input  logic [7:0]  cmd_frames_i,
    input  logic [19:0] cmd_shutter_i,
    input  logic        abort_i,
    input  logic        vact_i,
    output logic [1:0]  reg_a_o,
    output logic [7:0]  reg_d_o,
    output logic        reg_we_o,
    output logic        trigger_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic [7:0]  frames_left_o,
    output logic        timeout_err_o
);

    typedef enum logic [3:0] {
        IDLE, WR1, WR2, WR3, SETTLE, TRIG, LINES, FDONE, DRAIN
    } state_t;

    localparam logic [1:0]  MODE_SINGLE = 2'b00;
    localparam logic [1:0]  MODE_BURST  = 2'b01;
    localparam logic [1:0]  MODE_CONT   = 2'b10;
    localparam logic [11:0] LINES_LAST  = 12'(LINES_PER_FRAME);
    localparam logic [13:0] TMO_LAST    = 14'(LINE_TIMEOUT - 1);
    localparam logic [13:0] DRAIN_LAST  = 14'(DRAIN_CYCLES - 1);
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_q;
    logic [1:0]  mode_q;
    logic [19:0] shutter_q;
    logic [7:0]  frames_left_q;
    logic [11:0] line_cnt_q;
    logic [13:0] line_tmr_q;
    logic [13:0] drain_q;
    logic [3:0]  settle_q;
    logic        vact_q;
    logic [1:0]  reg_a_q;
    logic [7:0]  reg_d_q;
    logic        reg_we_q;
    logic        trigger_q;
    logic        frame_done_q;
    logic        timeout_err_q;
    logic        vact_rise;
    logic        vact_fall;

    // vact is already in this clock domain, so one register suffices for edge detection
    assign vact_rise = vact_i & ~vact_q;
    assign vact_fall = ~vact_i & vact_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mode_q        <= MODE_SINGLE;
            shutter_q     <= '0;
            frames_left_q <= '0;
            line_cnt_q    <= '0;
            line_tmr_q    <= '0;
            drain_q       <= '0;
            settle_q      <= '0;
            vact_q        <= 1'b0;
            reg_a_q       <= '0;
            reg_d_q       <= '0;
            reg_we_q      <= 1'b0;
            trigger_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            vact_q       <= vact_i;
            reg_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            // Abort wins over every transition; DRAIN already is the abort destination
            if (abort_i && state_q != IDLE && state_q != DRAIN) begin
                state_q       <= DRAIN;
                trigger_q     <= 1'b0;
                frames_left_q <= '0;
                drain_q       <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cmd_valid_i && !abort_i) begin
                            state_q       <= WR1;
                            mode_q        <= (cmd_mode_i == 2'b11) ? MODE_SINGLE : cmd_mode_i;
                            shutter_q     <= cmd_shutter_i;
                            timeout_err_q <= 1'b0;
                            if (cmd_mode_i == MODE_BURST)
                                frames_left_q <= (cmd_frames_i == 8'd0) ? 8'd1 : cmd_frames_i;
                            else
                                frames_left_q <= '0;
                            reg_we_q <= 1'b1;
                            reg_a_q  <= 2'd1;
                            reg_d_q  <= {4'b0, cmd_shutter_i[19:16]};
                        end
                    end
                    WR1: begin
                        state_q  <= WR2;
                        reg_we_q <= 1'b1;
                        reg_a_q  <= 2'd2;
                        reg_d_q  <= shutter_q[15:8];
                    end
                    WR2: begin
                        state_q  <= WR3;
                        reg_we_q <= 1'b1;
                        reg_a_q  <= 2'd3;
                        reg_d_q  <= shutter_q[7:0];
                    end
                    WR3: begin
                        state_q  <= SETTLE;
                        settle_q <= '0;
                    end
                    SETTLE: begin
                        if (settle_q == SETTLE_LAST) begin
                            state_q   <= TRIG;
                            trigger_q <= 1'b1;
                        end else begin
                            settle_q <= settle_q + 4'd1;
                        end
                    end
                    TRIG: begin
                        // The rising edge that ends the trigger is line 1 of the frame
                        if (vact_rise) begin
                            state_q    <= LINES;
                            trigger_q  <= 1'b0;
                            line_cnt_q <= 12'd1;
                            line_tmr_q <= '0;
                        end
                    end
                    LINES: begin
                        if (vact_rise) begin
                            if (line_cnt_q != '1)
                                line_cnt_q <= line_cnt_q + 12'd1;
                            line_tmr_q <= '0;
                        end else if (vact_fall && line_cnt_q == LINES_LAST) begin
                            state_q      <= FDONE;
                            frame_done_q <= 1'b1;
                        end else if (!vact_i) begin
                            if (line_tmr_q == TMO_LAST) begin
                                state_q       <= DRAIN;
                                timeout_err_q <= 1'b1;
                                drain_q       <= '0;
                            end else begin
                                line_tmr_q <= line_tmr_q + 14'd1;
                            end
                        end
                    end
                    FDONE: begin
                        case (mode_q)
                            MODE_BURST: begin
                                frames_left_q <= frames_left_q - 8'd1;
                                if (frames_left_q == 8'd1) begin
                                    state_q <= IDLE;
                                end else begin
                                    state_q   <= TRIG;
                                    trigger_q <= 1'b1;
                                end
                            end
                            MODE_CONT: begin
                                state_q   <= TRIG;
                                trigger_q <= 1'b1;
                            end
                            default: state_q <= IDLE;
                        endcase
                    end
                    DRAIN: begin
                        if (vact_i)
                            drain_q <= '0;
                        else if (drain_q == DRAIN_LAST)
                            state_q <= IDLE;
                        else
                            drain_q <= drain_q + 14'd1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign cmd_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign reg_a_o       = reg_a_q;
    assign reg_d_o       = reg_d_q;
    assign reg_we_o      = reg_we_q;
    assign trigger_o     = trigger_q;
    assign frame_done_o  = frame_done_q;
    assign frames_left_o = frames_left_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: single, burst, continuous+abort, line timeout
// and reset cases, with expected values worked out by hand from the intended behaviour.
module tb_capture_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmdValid;
    logic        cmdReady;
    logic [1:0]  cmdMode;
    logic [7:0]  cmdFrames;
    logic [19:0] cmdShutter;
    logic        abortIn;
    logic        vact;
    logic [1:0]  regA;
    logic [7:0]  regD;
    logic        regWe;
    logic        trigger;
    logic        busy;
    logic        frameDone;
    logic [7:0]  framesLeft;
    logic        timeoutErr;

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;
    int doneCount  = 0;
    int trigCount  = 0;
    logic trigPrev = 1'b0;
    int d0;
    int t0;

    localparam logic [23:0] RESET_VEC = 24'h000001;

    capture_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid_i   (cmdValid),
        .cmd_ready_o   (cmdReady),
        .cmd_mode_i    (cmdMode),
        .cmd_frames_i  (cmdFrames),
        .cmd_shutter_i (cmdShutter),
        .abort_i       (abortIn),
        .vact_i        (vact),
        .reg_a_o       (regA),
        .reg_d_o       (regD),
        .reg_we_o      (regWe),
        .trigger_o     (trigger),
        .busy_o        (busy),
        .frame_done_o  (frameDone),
        .frames_left_o (framesLeft),
        .timeout_err_o (timeoutErr)
    );

    always #5 clk = ~clk;

    // Counts frame_done pulses and trigger rising edges one cycle after they appear
    always @(posedge clk) begin
        trigPrev <= trigger;
        if (frameDone) doneCount <= doneCount + 1;
        if (trigger && !trigPrev) trigCount <= trigCount + 1;
    end

    function automatic logic [23:0] outVec();
        return {regA, regD, regWe, trigger, busy, frameDone, framesLeft, timeoutErr, cmdReady};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sendLines(input int n);
        for (int i = 0; i < n; i++) begin
            vact = 1'b1;
            tick();
            vact = 1'b0;
            tick();
        end
    endtask

    // Presents a command for one edge; returns at the negedge where WR1 is visible
    task automatic applyStimulus(input logic [1:0] mode, input logic [7:0] frames,
                                 input logic [19:0] shutter, input logic holdValid);
        cmdValid   = 1'b1;
        cmdMode    = mode;
        cmdFrames  = frames;
        cmdShutter = shutter;
        tick();
        if (!holdValid) cmdValid = 1'b0;
    endtask

    task automatic waitTrigger(input string tag);
        int k = 0;
        while (!trigger && k < 64) begin
            tick();
            k++;
        end
        checkOutput(tag, 32'(trigger), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; cmdValid = 1'b0; cmdMode = 2'b00; cmdFrames = 8'd0;
        cmdShutter = 20'd0; abortIn = 1'b0; vact = 1'b0;
        tick(3);
        checkOutput("resetState", 32'(outVec()), 32'(RESET_VEC));
        rst = 1'b0;
        tick();

        // Abort together with a command in IDLE must not accept it
        abortIn = 1'b1; cmdValid = 1'b1;
        tick();
        checkOutput("abortIdle", 32'(busy), 32'd0);
        abortIn = 1'b0; cmdValid = 1'b0;
        tick();

        // Single frame, shutter 0x12345
        d0 = doneCount;
        applyStimulus(2'b00, 8'd0, 20'h12345, 1'b0);
        checkOutput("wr1", {21'd0, regWe, regA, regD}, {21'd0, 1'b1, 2'd1, 8'h01});
        tick();
        checkOutput("wr2", {21'd0, regWe, regA, regD}, {21'd0, 1'b1, 2'd2, 8'h23});
        tick();
        checkOutput("wr3", {21'd0, regWe, regA, regD}, {21'd0, 1'b1, 2'd3, 8'h45});
        tick(4);
        checkOutput("settleNoTrig", {30'd0, regWe, trigger}, 32'd0);
        tick();
        checkOutput("trigLatency", 32'(trigger), 32'd1);
        tick(20);
        checkOutput("trigHold", 32'(trigger), 32'd1);
        sendLines(3325);
        checkOutput("singleDone", 32'(frameDone), 32'd1);
        tick();
        checkOutput("singleIdle", {29'd0, busy, cmdReady, frameDone}, {29'd0, 3'b010});
        checkOutput("singleDoneCount", 32'(doneCount - d0), 32'd1);

        // Burst of 3 frames
        d0 = doneCount; t0 = trigCount;
        applyStimulus(2'b01, 8'd3, 20'h00010, 1'b0);
        waitTrigger("burstTrig1");
        checkOutput("burstLeft3", 32'(framesLeft), 32'd3);
        sendLines(3325);
        tick();
        checkOutput("burstLeft2", {23'd0, trigger, framesLeft}, {23'd0, 1'b1, 8'd2});
        sendLines(3325);
        tick();
        checkOutput("burstLeft1", {23'd0, trigger, framesLeft}, {23'd0, 1'b1, 8'd1});
        sendLines(3325);
        tick();
        checkOutput("burstEnd", {22'd0, trigger, busy, framesLeft}, 32'd0);
        checkOutput("burstDoneCount", 32'(doneCount - d0), 32'd3);
        checkOutput("burstTrigCount", 32'(trigCount - t0), 32'd3);

        // Burst with frames=0 acts as one frame; cmd_valid held while busy
        d0 = doneCount; t0 = trigCount;
        applyStimulus(2'b01, 8'd0, 20'hABCDE, 1'b1);
        cmdShutter = 20'h55555;
        checkOutput("holdWr1", {21'd0, regWe, regA, regD}, {21'd0, 1'b1, 2'd1, 8'h0A});
        tick();
        checkOutput("holdWr2", {21'd0, regWe, regA, regD}, {21'd0, 1'b1, 2'd2, 8'hBC});
        tick();
        checkOutput("holdWr3", {21'd0, regWe, regA, regD}, {21'd0, 1'b1, 2'd3, 8'hDE});
        waitTrigger("burst0Trig");
        checkOutput("burst0Left", {23'd0, cmdReady, framesLeft}, {23'd0, 1'b0, 8'd1});
        sendLines(3324);
        cmdValid = 1'b0;
        sendLines(1);
        tick();
        checkOutput("burst0Idle", 32'(busy), 32'd0);
        checkOutput("burst0DoneCount", 32'(doneCount - d0), 32'd1);
        checkOutput("burst0TrigCount", 32'(trigCount - t0), 32'd1);

        // Continuous, abort on line 100 of frame 2
        d0 = doneCount;
        applyStimulus(2'b10, 8'd0, 20'h00001, 1'b0);
        waitTrigger("contTrig1");
        sendLines(3325);
        tick();
        checkOutput("contRetrig", 32'(trigger), 32'd1);
        sendLines(99);
        vact = 1'b1; abortIn = 1'b1;
        tick();
        checkOutput("abortEdge", {21'd0, trigger, busy, frameDone, framesLeft},
                    {21'd0, 1'b0, 1'b1, 1'b0, 8'd0});
        abortIn = 1'b0; vact = 1'b0;
        tick(8191);
        checkOutput("drainHold", 32'(busy), 32'd1);
        tick();
        checkOutput("drainDone", 32'(busy), 32'd0);
        checkOutput("contDoneCount", 32'(doneCount - d0), 32'd1);

        // Line timeout after line 50
        applyStimulus(2'b00, 8'd0, 20'h00002, 1'b0);
        waitTrigger("tmoTrig");
        sendLines(50);
        tick(8190);
        checkOutput("tmoNotYet", {30'd0, busy, timeoutErr}, {30'd0, 2'b10});
        tick();
        checkOutput("tmoSet", {30'd0, busy, timeoutErr}, {30'd0, 2'b11});
        tick(8191);
        checkOutput("tmoDrainHold", 32'(busy), 32'd1);
        tick();
        checkOutput("tmoIdle", {30'd0, busy, timeoutErr}, {30'd0, 2'b01});

        // Next accept clears timeout_err; reset while in WR2
        applyStimulus(2'b00, 8'd0, 20'h00003, 1'b0);
        checkOutput("tmoClear", 32'(timeoutErr), 32'd0);
        tick();
        checkOutput("inWr2", {29'd0, regWe, regA}, {29'd0, 1'b1, 2'd2});
        rst = 1'b1;
        tick();
        checkOutput("rstWr2", 32'(outVec()), 32'(RESET_VEC));
        rst = 1'b0;
        tick();

        // Reset while counting lines
        applyStimulus(2'b00, 8'd0, 20'h00004, 1'b0);
        waitTrigger("rstLinesTrig");
        sendLines(10);
        vact = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        checkOutput("rstLines", 32'(outVec()), 32'(RESET_VEC));
        rst = 1'b0; vact = 1'b0;
        tick(2);
        checkOutput("rstLinesIdle", 32'(busy), 32'd0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
